// File: rtl/regfile_multiport.sv
// Two-read / one-write register file with byte-lane writes, optional zero
// register, optional write-to-read bypass and a self-clearing sweep FSM that
// zeroes the array after reset or on request.
module regfile_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    output logic                ready,
    output logic                wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic                wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                sweep_last;
    logic                write_ok;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [NB-1:0]       mem_wbe;

    // Old value with the enabled byte lanes replaced by the new value.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return res;
    endfunction

    assign sweep_last = (clr_ptr_q == ADDR_W'(DEPTH - 1));
    // A user write lands only in READY, without a concurrent clear, and never
    // on the hard-wired zero register.
    assign write_ok   = (state_q == ST_READY) && wr_en && !clr &&
                        !((ZERO_REG != 0) && (wr_addr == '0));

    // State register: FSM state, sweep pointer and sticky drop flag.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Next-state logic: sweep the array, accept clear requests, flag drops.
    always_comb begin
        // NOTE: hold-value defaults first so no path infers a latch.
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        wr_drop_d = wr_drop_q;
        unique case (state_q)
            ST_CLEAR: begin
                // Pointer parks on the last address; it never wraps.
                if (sweep_last) state_d   = ST_READY;
                else            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (wr_en)      wr_drop_d = 1'b1;
            end
            ST_READY: begin
                if (clr) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                    if (wr_en) wr_drop_d = 1'b1;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Output logic: status flags straight from the state register.
    always_comb begin
        ready   = (state_q == ST_READY);
        wr_drop = wr_drop_q;
    end

    // Single memory write port: the sweep owns it in CLEAR, users in READY.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_wbe   = '0;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wbe   = '1;
        end else if (write_ok) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = wr_data;
            mem_wbe   = wr_be;
        end
    end

    // Storage array with per-byte write enables.
    always_ff @(posedge clk) begin
        // NOTE: no reset on the array; the CLEAR sweep zeroes it, keeping it RAM-mappable.
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_wbe[i]) mem_q[mem_waddr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
            end
        end
    end

    // Read port 1: gated by ready and the zero register, optionally bypassed.
    always_comb begin
        rd_data1 = '0;
        if (ready && !((ZERO_REG != 0) && (rd_addr1 == '0))) begin
            if ((BYPASS != 0) && wr_en && !clr && (wr_addr == rd_addr1))
                rd_data1 = byte_merge(mem_q[rd_addr1], wr_data, wr_be);
            else
                rd_data1 = mem_q[rd_addr1];
        end
    end

    // Read port 2: identical behaviour, independent address.
    always_comb begin
        rd_data2 = '0;
        if (ready && !((ZERO_REG != 0) && (rd_addr2 == '0))) begin
            if ((BYPASS != 0) && wr_en && !clr && (wr_addr == rd_addr2))
                rd_data2 = byte_merge(mem_q[rd_addr2], wr_data, wr_be);
            else
                rd_data2 = mem_q[rd_addr2];
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: directed sweep/reset sequences, a vector table
// for the write/read rules, and randomized traffic against a reference model.
// A second instance with bypass disabled shares all inputs.
module tb_regfile_multiport;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int NB    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [NB-1:0] wr_be = '0;
    logic [AW-1:0] rd_addr1 = '0;
    logic [AW-1:0] rd_addr2 = '0;
    logic [DW-1:0] rd_data1, rd_data2, nb_rd_data1, nb_rd_data2;
    logic          ready, wr_drop, nb_ready, nb_wr_drop;

    int n_checks = 0;
    int n_errors = 0;

    regfile_multiport dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .ready(ready), .wr_drop(wr_drop)
    );

    regfile_multiport #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(nb_rd_data1), .rd_data2(nb_rd_data2), .ready(nb_ready), .wr_drop(nb_wr_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    // Abstract view: after a reset or accepted clear the file is busy for
    // DEPTH cycles and then holds all zeros; while busy every write is dropped.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_busy;
    bit            m_drop;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        for (int i = 0; i < NB; i++) r[i*8 +: 8] = be[i] ? n[i*8 +: 8] : o[i*8 +: 8];
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= DEPTH;
            m_drop <= 1'b0;
            foreach (m_mem[i]) m_mem[i] <= '0;
        end else if (m_busy > 0) begin
            m_busy <= m_busy - 1;
            if (wr_en) m_drop <= 1'b1;
        end else if (clr) begin
            m_busy <= DEPTH;
            foreach (m_mem[i]) m_mem[i] <= '0;
            if (wr_en) m_drop <= 1'b1;
        end else if (wr_en && wr_addr != 0) begin
            m_mem[wr_addr] <= merge(m_mem[wr_addr], wr_data, wr_be);
        end
    end

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (m_busy != 0 || a == 0) return '0;
        if (byp && wr_en && !clr && a == wr_addr) return merge(m_mem[a], wr_data, wr_be);
        return m_mem[a];
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    endtask

    // Wait (bounded) for ready and compare the number of edges it took.
    task automatic wait_ready(input string name, input int exp_edges);
        int n = 0;
        while (!ready && n < 64) begin
            step();
            n++;
        end
        check(name, DW'(n), DW'(exp_edges));
    endtask

    typedef struct {
        logic          clr;
        logic          wen;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [NB-1:0] be;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        logic          er;
    } vec_t;

    vec_t vt [10];

    initial begin
        vt[0] = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5, 5'd6, 32'hDEADBEEF, 32'h0, 1'b1};
        vt[1] = '{1'b0, 1'b1, 5'd5, 32'h00001234, 4'h3, 5'd5, 5'd5, 32'hDEAD1234, 32'hDEAD1234, 1'b1};
        vt[2] = '{1'b0, 1'b0, 5'd0, 32'h0,        4'h0, 5'd5, 5'd0, 32'hDEAD1234, 32'h0, 1'b1};
        vt[3] = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1};
        vt[4] = '{1'b0, 1'b0, 5'd0, 32'h0,        4'h0, 5'd0, 5'd5, 32'h0, 32'hDEAD1234, 1'b1};
        vt[5] = '{1'b0, 1'b1, 5'd9, 32'h11223344, 4'h0, 5'd9, 5'd5, 32'h0, 32'hDEAD1234, 1'b1};
        vt[6] = '{1'b0, 1'b1, 5'd9, 32'hAABBCCDD, 4'hA, 5'd9, 5'd9, 32'hAA00CC00, 32'hAA00CC00, 1'b1};
        vt[7] = '{1'b0, 1'b0, 5'd0, 32'h0,        4'h0, 5'd9, 5'd5, 32'hAA00CC00, 32'hDEAD1234, 1'b1};
        vt[8] = '{1'b1, 1'b1, 5'd9, 32'h12345678, 4'hF, 5'd9, 5'd5, 32'hAA00CC00, 32'hDEAD1234, 1'b1};
        vt[9] = '{1'b0, 1'b0, 5'd0, 32'h0,        4'h0, 5'd9, 5'd5, 32'h0, 32'h0, 1'b0};

        // Reset state.
        idle();
        @(negedge clk);
        #1;
        check("reset_ready", DW'(ready), 0);
        check("reset_drop", DW'(wr_drop), 0);
        check("reset_rd1", rd_data1, 0);

        // Release reset; a write at edge 3 is dropped; ready rises on edge 32.
        rst = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            if (e == 3) begin
                wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h87654321; wr_be = 4'hF;
            end else begin
                idle();
            end
            step();
            #1;
            check($sformatf("ready_edge%0d", e), DW'(ready), DW'(e == 32));
        end
        rd_addr1 = 5'd4; rd_addr2 = 5'd0;
        #1;
        check("drop_in_clear", DW'(wr_drop), 1);
        check("sweep_rd1", rd_data1, 0);
        check("sweep_rd2", rd_data2, 0);

        // Asynchronous reset between edges clears status immediately.
        #1;
        rst = 1'b0;
        #1;
        check("async_ready", DW'(ready), 0);
        check("async_drop", DW'(wr_drop), 0);
        check("async_rd1", rd_data1, 0);
        @(negedge clk);
        rst = 1'b1;
        wait_ready("ready_after_reset", 32);

        // Vector table: byte lanes, bypass, zero register, clear-collision drop.
        for (int i = 0; i < 10; i++) begin
            clr = vt[i].clr; wr_en = vt[i].wen; wr_addr = vt[i].wa;
            wr_data = vt[i].wd; wr_be = vt[i].be;
            rd_addr1 = vt[i].ra1; rd_addr2 = vt[i].ra2;
            #1;
            check($sformatf("vec%0d_rd1", i), rd_data1, vt[i].e1);
            check($sformatf("vec%0d_rd2", i), rd_data2, vt[i].e2);
            check($sformatf("vec%0d_ready", i), DW'(ready), DW'(vt[i].er));
            if (i == 7) check("no_drop_before_clr", DW'(wr_drop), 0);
            step();
        end
        idle();
        check("drop_on_clr_write", DW'(wr_drop), 1);
        wait_ready("ready_after_clr", 31);

        // Same-cycle bypass versus non-bypassed instance.
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; wr_be = 4'hF;
        rd_addr2 = 5'd7;
        #1;
        check("bypass_same_cycle", rd_data2, 32'hA5A5A5A5);
        check("nobypass_same_cycle", nb_rd_data2, 32'h0);
        step();
        idle();
        #1;
        check("bypass_next_cycle", rd_data2, 32'hA5A5A5A5);
        check("nobypass_next_cycle", nb_rd_data2, 32'hA5A5A5A5);
        step();

        // Fill, then clear: ready low for 32 cycles, then everything reads 0.
        for (int a = 1; a < DEPTH; a++) begin
            wr_en = 1'b1; wr_addr = AW'(a); wr_data = 32'hC0DE0000 | DW'(a); wr_be = 4'hF;
            step();
        end
        idle();
        rd_addr1 = 5'd31;
        #1;
        check("fill_last", rd_data1, 32'hC0DE001F);
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check($sformatf("clr_busy%0d", k), DW'(ready), 0);
            step();
        end
        check("clr_done", DW'(ready), 1);
        for (int a = 0; a < DEPTH; a += 2) begin
            rd_addr1 = AW'(a); rd_addr2 = AW'(a + 1);
            #1;
            check($sformatf("cleared_%0d", a), rd_data1, 0);
            check($sformatf("cleared_%0d", a + 1), rd_data2, 0);
            step();
        end

        // Reset in the middle of a sweep restarts it from address 0.
        clr = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_be = 4'hF;
        step();
        idle();
        for (int k = 0; k < 10; k++) step();
        check("drop_before_midreset", DW'(wr_drop), 1);
        #2;
        rst = 1'b0;
        #1;
        check("midsweep_ready", DW'(ready), 0);
        check("midsweep_drop", DW'(wr_drop), 0);
        check("midsweep_rd", rd_data1, 0);
        @(negedge clk);
        rst = 1'b1;
        wait_ready("ready_after_midreset", 32);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            clr     = ($urandom_range(0, 63) == 0);
            wr_en   = $urandom_range(0, 1);
            wr_addr = AW'($urandom_range(0, DEPTH - 1));
            wr_data = $urandom;
            wr_be   = NB'($urandom_range(0, 15));
            // Writes colliding with a clear always target a real register.
            if (m_busy != 0 || clr) begin
                wr_addr = AW'($urandom_range(1, DEPTH - 1));
                wr_be   = NB'($urandom_range(1, 15));
            end
            rd_addr1 = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
            rd_addr2 = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
            #1;
            check("rnd_ready", DW'(ready), DW'(m_busy == 0));
            check("rnd_drop", DW'(wr_drop), DW'(m_drop));
            check("rnd_rd1", rd_data1, exp_rd(rd_addr1, 1'b1));
            check("rnd_rd2", rd_data2, exp_rd(rd_addr2, 1'b1));
            check("rnd_nb_rd1", nb_rd_data1, exp_rd(rd_addr1, 1'b0));
            check("rnd_nb_rd2", nb_rd_data2, exp_rd(rd_addr2, 1'b0));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
